instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the 32-bit synchronous-read instruction memory.
- Owns the program counter and drives the memory word address.
- Absorbs the memory's one-cycle read latency and presents {instruction, pc} to decode through a 2-entry buffer with a valid/ready handshake.
- Redirects on a taken branch and discards wrong-path fetches.

---
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous-read instruction memory and
// hides its one-cycle latency behind a 2-entry {instruction, pc} output buffer.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned PC_STEP    = 4,
   parameter int unsigned ADDR_SHIFT = 2,
   parameter int unsigned BUF_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        if_ready,
   output logic        if_valid,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc
);

   logic [31:0] pc_q, pc_d;
   logic        inflight_q, inflight_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic [31:0] buf_instr_q [2];
   logic [31:0] buf_instr_d [2];
   logic [31:0] buf_pc_q [2];
   logic [31:0] buf_pc_d [2];

   logic        pop;
   logic        push;
   logic        issue;
   logic        tail;
   logic [2:0]  occupancy;
   logic [31:0] fetch_addr;

   // Occupancy counts the slot an in-flight read will claim next cycle, so the
   // buffer can never be pushed while full.
   always_comb begin
      pop        = (count_q != 2'd0) & if_ready;
      push       = inflight_q & ~branch_taken;
      occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue      = branch_taken | (occupancy < 3'(BUF_DEPTH));
      fetch_addr = (branch_taken && reset_n) ? branch_target : pc_q;
      tail       = head_q ^ count_q[0];
   end

   assign imem_address = fetch_addr >> ADDR_SHIFT;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (issue) begin
         pc_d          = fetch_addr + 32'(PC_STEP);
         inflight_pc_d = fetch_addr;
      end
   end

   always_comb begin
      count_d     = count_q;
      head_d      = head_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      if (branch_taken) begin
         count_d = 2'd0;
      end else begin
         if (push) begin
            buf_instr_d[tail] = imem_instruction;
            buf_pc_d[tail]    = inflight_pc_q;
         end
         if (pop) begin
            head_d = ~head_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         count_q       <= 2'd0;
         head_q        <= 1'b0;
         buf_instr_q   <= '{default: 32'h0};
         buf_pc_q      <= '{default: 32'h0};
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         head_q        <= head_d;
         buf_instr_q   <= buf_instr_d;
         buf_pc_q      <= buf_pc_d;
      end
   end

   assign if_valid       = (count_q != 2'd0);
   assign if_instruction = buf_instr_q[head_q];
   assign if_pc          = buf_pc_q[head_q];

   a_no_push_when_full : assert property (
      @(posedge clk) disable iff (!reset_n) !(push && count_q == 2'd2)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a synchronous-read memory model;
// words 0..9 hold 10..1, higher words hold 0x100+index.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction = 32'h0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        if_ready = 1'b1;
   logic        if_valid;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [64];

   instruction_fetch_unit dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .if_ready         (if_ready),
      .if_valid         (if_valid),
      .if_instruction   (if_instruction),
      .if_pc            (if_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_instruction <= mem[imem_address[5:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] instr, input logic [31:0] pc);
      check({tag, ".valid"}, {31'h0, if_valid}, 32'h1);
      check({tag, ".instr"}, if_instruction, instr);
      check({tag, ".pc"}, if_pc, pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      for (int i = 0; i < 64; i++) mem[i] = (i < 10) ? 32'(10 - i) : 32'(32'h100 + i);

      // Reset state
      step();
      step();
      check("rst.valid", {31'h0, if_valid}, 32'h0);
      check("rst.instr", if_instruction, 32'h0);
      check("rst.pc", if_pc, 32'h0);
      check("rst.addr", imem_address, 32'h0);

      // Release: valid appears two edges later, then a bubble-free stream
      reset_n = 1'b1;
      step();
      check("lat.valid0", {31'h0, if_valid}, 32'h0);
      step();
      expect_out("s0", 32'd10, 32'h0);
      step();
      expect_out("s1", 32'd9, 32'h4);
      step();
      expect_out("s2", 32'd8, 32'h8);
      step();
      expect_out("s3", 32'd7, 32'hC);

      // Backpressure for 5 cycles: head holds, address frozen at pc=0x14
      if_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_out("bp.hold", 32'd7, 32'hC);
         check("bp.addr", imem_address, 32'h5);
      end
      if_ready = 1'b1;
      step();
      expect_out("bp.r0", 32'd6, 32'h10);
      step();
      expect_out("bp.r1", 32'd5, 32'h14);
      step();
      expect_out("bp.r2", 32'd4, 32'h18);

      // Fill buffer to 2 entries, then redirect to 0x14
      if_ready = 1'b0;
      step();
      expect_out("br.pre", 32'd4, 32'h18);
      if_ready = 1'b1;
      branch_taken = 1'b1;
      branch_target = 32'h14;
      #1;
      check("br.addr", imem_address, 32'h5);
      step();
      branch_taken = 1'b0;
      check("br.bubble", {31'h0, if_valid}, 32'h0);
      step();
      expect_out("br.t0", 32'd5, 32'h14);
      step();
      expect_out("br.t1", 32'd4, 32'h18);
      step();
      expect_out("br.t2", 32'd3, 32'h1C);

      // Back-to-back redirects: only the 0x20 stream survives
      branch_taken = 1'b1;
      branch_target = 32'h0;
      step();
      check("bb.bubble0", {31'h0, if_valid}, 32'h0);
      branch_target = 32'h20;
      step();
      branch_taken = 1'b0;
      check("bb.bubble1", {31'h0, if_valid}, 32'h0);
      step();
      expect_out("bb.t0", 32'd2, 32'h20);
      step();
      expect_out("bb.t1", 32'd1, 32'h24);
      step();
      expect_out("bb.t2", 32'h10A, 32'h28);

      // if_ready toggling: words 10..1 each delivered once, in order
      branch_taken = 1'b1;
      branch_target = 32'h0;
      step();
      branch_taken = 1'b0;
      k = 0;
      for (int c = 0; c < 60 && k < 10; c++) begin
         if_ready = c[0] ? 1'b0 : 1'b1;
         if (if_valid && if_ready) begin
            check("tg.instr", if_instruction, 32'(10 - k));
            check("tg.pc", if_pc, 32'(4 * k));
            k++;
         end
         step();
      end
      check("tg.count", 32'(k), 32'd10);

      // Mid-stream reset with 2 entries buffered
      if_ready = 1'b0;
      step();
      step();
      check("mr.full", {31'h0, if_valid}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("mr.valid", {31'h0, if_valid}, 32'h0);
      check("mr.instr", if_instruction, 32'h0);
      check("mr.pc", if_pc, 32'h0);
      check("mr.addr", imem_address, 32'h0);
      if_ready = 1'b1;
      step();
      reset_n = 1'b1;
      step();
      check("mr.lat", {31'h0, if_valid}, 32'h0);
      step();
      expect_out("mr.s0", 32'd10, 32'h0);
      step();
      expect_out("mr.s1", 32'd9, 32'h4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
